cgra_config_sequencer: RTL and testbench

Controller in front of the CGRA `top` configuration port. It accepts (addr, data) configuration words over a valid/ready stream and drives them onto config_addr/config_data, one word per cycle. It then waits a settle interval, enables the datapath for a programmed number of cycles, and reports completion. It replaces the file-driven config loading and max-cycle run control done ad hoc in system benches, and is reusable on-chip behind a host/DMA interface.

---
 rtl/cgra_cfg_pkg.sv | 15 +
 rtl/cfg_sat_counter.sv | 28 ++
 rtl/cgra_config_sequencer.sv | 174 +++++++++++++++++
 tb/tb_cgra_config_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_cfg_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
package cgra_cfg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        RUN,
        DONE
    } cfg_seq_state_t;

    localparam int WORD_CNT_W   = 16;
    localparam int CFG_NOP_ADDR = 0;

endpackage

// File: rtl/cfg_sat_counter.sv
// Up-counter with synchronous clear and optional saturation at all-ones.
module cfg_sat_counter #(
    parameter int WIDTH  = 16,
    parameter bit SAT_EN = 1'b1
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;
    logic             at_max;

    assign at_max = SAT_EN && (count_reg == {WIDTH{1'b1}});

    always_ff @(posedge clk_in) begin
        if (!reset_in || clear) begin
            count_reg <= '0;
        end else if (inc && !at_max) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/cgra_config_sequencer.sv
// Streams (addr, data) config words onto the CGRA config port, settles, then runs the
// datapath for a programmed cycle count. Optional CFG_CHECKSUM_EN adds cfg_checksum.
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int CYC_W         = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic                  start,
    input  logic [CYC_W-1:0]      run_cycles,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [ADDR_W-1:0]     cfg_addr,
    input  logic [DATA_W-1:0]     cfg_data,
    input  logic                  cfg_last,
    output logic [ADDR_W-1:0]     config_addr_out,
    output logic [DATA_W-1:0]     config_data_out,
    output logic                  run_en,
    output logic                  busy,
    output logic                  config_done,
    output logic                  run_done,
    output logic [WORD_CNT_W-1:0] word_count,
    output logic [CYC_W-1:0]      cycle_count
`ifdef CFG_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     cfg_checksum
`endif
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be >= 1");
        end
    endgenerate

    cfg_seq_state_t    state_reg;
    logic [SET_W-1:0]  settle_cnt_reg;
    logic [CYC_W-1:0]  run_len_reg;
    logic              cfg_ready_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] data_reg;
    logic              run_en_reg;
    logic              busy_reg;
    logic              config_done_reg;
    logic              run_done_reg;

    logic transfer;
    logic restart;
    logic last_run;

    assign transfer = cfg_valid && cfg_ready_reg;
    // start is only honoured when no job is in flight
    assign restart  = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign last_run = (state_reg == RUN) && (cycle_count == run_len_reg - CYC_W'(1));

    cfg_sat_counter #(.WIDTH(WORD_CNT_W), .SAT_EN(1'b1)) u_word_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (restart),
        .inc      (transfer),
        .count    (word_count)
    );

    cfg_sat_counter #(.WIDTH(CYC_W), .SAT_EN(1'b0)) u_cycle_cnt (
        .clk_in   (clk_in),
        .reset_in (reset_in),
        .clear    (restart),
        .inc      (state_reg == RUN),
        .count    (cycle_count)
    );

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            state_reg       <= IDLE;
            settle_cnt_reg  <= '0;
            run_len_reg     <= '0;
            cfg_ready_reg   <= 1'b0;
            addr_reg        <= '0;
            data_reg        <= '0;
            run_en_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            config_done_reg <= 1'b0;
            run_done_reg    <= 1'b0;
        end else begin
            // The bus carries a word for exactly one cycle, otherwise the no-op address
            addr_reg <= transfer ? cfg_addr : ADDR_W'(CFG_NOP_ADDR);
            data_reg <= transfer ? cfg_data : '0;

            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        state_reg       <= LOAD;
                        run_len_reg     <= run_cycles;
                        cfg_ready_reg   <= 1'b1;
                        busy_reg        <= 1'b1;
                        config_done_reg <= 1'b0;
                        run_done_reg    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (transfer && cfg_last) begin
                        state_reg      <= SETTLE;
                        cfg_ready_reg  <= 1'b0;
                        settle_cnt_reg <= '0;
                    end
                end
                SETTLE: begin
                    config_done_reg <= 1'b1;
                    if (settle_cnt_reg == SET_W'(SETTLE_CYCLES - 1)) begin
                        if (run_len_reg == '0) begin
                            state_reg    <= DONE;
                            busy_reg     <= 1'b0;
                            run_done_reg <= 1'b1;
                        end else begin
                            state_reg  <= RUN;
                            run_en_reg <= 1'b1;
                        end
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + SET_W'(1);
                    end
                end
                RUN: begin
                    if (last_run) begin
                        state_reg    <= DONE;
                        run_en_reg   <= 1'b0;
                        busy_reg     <= 1'b0;
                        run_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign cfg_ready       = cfg_ready_reg;
    assign config_addr_out = addr_reg;
    assign config_data_out = data_reg;
    assign run_en          = run_en_reg;
    assign busy            = busy_reg;
    assign config_done     = config_done_reg;
    assign run_done        = run_done_reg;

`ifdef CFG_CHECKSUM_EN
    logic [DATA_W-1:0] addr_ext;
    logic [DATA_W-1:0] checksum_reg;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_addr_ext
            if (gi < ADDR_W) begin : g_bit
                assign addr_ext[gi] = cfg_addr[gi];
            end else begin : g_zero
                assign addr_ext[gi] = 1'b0;
            end
        end
    endgenerate

    always_ff @(posedge clk_in) begin
        if (!reset_in || restart) begin
            checksum_reg <= '0;
        end else if (transfer) begin
            checksum_reg <= checksum_reg ^ addr_ext ^ cfg_data;
        end
    end

    assign cfg_checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Scoreboard bench for cgra_config_sequencer: driver pushes expected bus words and run
// completions, a negedge monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_cgra_config_sequencer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CYC_W  = 32;
    localparam int SETTLE = 4;

    logic              clk_in = 1'b0;
    logic              reset_in = 1'b0;
    logic              start = 1'b0;
    logic [CYC_W-1:0]  run_cycles = '0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [DATA_W-1:0] cfg_data = '0;
    logic              cfg_last = 1'b0;
    logic [ADDR_W-1:0] config_addr_out;
    logic [DATA_W-1:0] config_data_out;
    logic              run_en;
    logic              busy;
    logic              config_done;
    logic              run_done;
    logic [15:0]       word_count;
    logic [CYC_W-1:0]  cycle_count;
`ifdef CFG_CHECKSUM_EN
    logic [DATA_W-1:0] cfg_checksum;
`endif

    cgra_config_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CYC_W(CYC_W), .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk_in          (clk_in),
        .reset_in        (reset_in),
        .start           (start),
        .run_cycles      (run_cycles),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .cfg_last        (cfg_last),
        .config_addr_out (config_addr_out),
        .config_data_out (config_data_out),
        .run_en          (run_en),
        .busy            (busy),
        .config_done     (config_done),
        .run_done        (run_done),
        .word_count      (word_count),
        .cycle_count     (cycle_count)
`ifdef CFG_CHECKSUM_EN
        ,
        .cfg_checksum    (cfg_checksum)
`endif
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc = cyc + 1;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          at;
    } bus_exp_t;

    typedef struct {
        int words;
        int cycles;
        int cfg_done_at;
        int run_first;
        int run_len;
        int done_at;
    } done_exp_t;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: decoupled from stimulus, compares against queued expectations
    logic prev_busy = 1'b0, prev_cfg_done = 1'b0, prev_run_en = 1'b0, prev_run_done = 1'b0;
    int   t_cfg_done = -1, t_run_first = -1, t_run_len = 0;

    always @(negedge clk_in) begin
        bus_exp_t  be;
        done_exp_t de;
        if (busy && !prev_busy) begin
            t_cfg_done  = -1;
            t_run_first = -1;
            t_run_len   = 0;
        end
        if (config_done && !prev_cfg_done) t_cfg_done = cyc;
        if (run_en) begin
            if (!prev_run_en) t_run_first = cyc;
            t_run_len++;
        end
        if (config_addr_out != '0 || config_data_out != '0) begin
            if (bus_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL bus_unexpected: got addr=0x%0h data=0x%0h at cycle %0d, expected idle bus",
                         config_addr_out, config_data_out, cyc);
            end else begin
                be = bus_q.pop_front();
                check("bus_addr", config_addr_out, be.a);
                check("bus_data", config_data_out, be.d);
                check("bus_cycle", cyc, be.at);
                $display("bus word addr=0x%0h data=0x%0h cycle=%0d", config_addr_out, config_data_out, cyc);
            end
        end
        if (run_done && !prev_run_done) begin
            if (done_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL done_unexpected: got run_done=1 at cycle %0d, expected no completion", cyc);
            end else begin
                de = done_q.pop_front();
                check("done_cycle", cyc, de.done_at);
                check("done_word_count", word_count, de.words);
                check("done_cycle_count", cycle_count, de.cycles);
                check("done_config_done", config_done, 1);
                check("done_busy", busy, 0);
                check("done_run_en", run_en, 0);
                check("cfg_done_rise", t_cfg_done, de.cfg_done_at);
                check("run_en_first", t_run_first, de.run_first);
                check("run_en_len", t_run_len, de.run_len);
                $display("run complete cycle=%0d words=%0d cycles=%0d", cyc, word_count, cycle_count);
            end
        end
        prev_busy     = busy;
        prev_cfg_done = config_done;
        prev_run_en   = run_en;
        prev_run_done = run_done;
    end

    task automatic check_idle(input string tag);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_run_en"}, run_en, 0);
        check({tag, "_config_done"}, config_done, 0);
        check({tag, "_run_done"}, run_done, 0);
        check({tag, "_word_count"}, word_count, 0);
        check({tag, "_cycle_count"}, cycle_count, 0);
        check({tag, "_bus_addr"}, config_addr_out, 0);
        check({tag, "_bus_data"}, config_data_out, 0);
    endtask

    task automatic do_start(input int rc);
        start      = 1'b1;
        run_cycles = rc;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    // Holds the word until accepted; returns the accepting edge number
    task automatic send_word(input logic [31:0] a, input logic [31:0] d, input bit last,
                             output int acc_edge);
        int g = 0;
        bus_exp_t be;
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_data  = d;
        cfg_last  = last;
        while (!cfg_ready && g < 50) begin
            @(negedge clk_in);
            g++;
        end
        acc_edge = cyc + 1;
        if (!cfg_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cfg_ready_timeout: got cfg_ready=0 for %0d cycles, expected 1", g);
        end else begin
            be.a = a;
            be.d = d;
            be.at = acc_edge;
            bus_q.push_back(be);
        end
        @(negedge clk_in);
        cfg_valid = 1'b0;
        cfg_last  = 1'b0;
    endtask

    task automatic expect_done(input int words, input int rc, input int e);
        done_exp_t de;
        de.words       = words;
        de.cycles      = rc;
        de.cfg_done_at = e + 1;
        de.run_first   = (rc == 0) ? -1 : e + SETTLE;
        de.run_len     = rc;
        de.done_at     = e + SETTLE + rc;
        done_q.push_back(de);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!run_done && g < 400) begin
            @(negedge clk_in);
            g++;
        end
        if (!run_done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got run_done=0 after %0d cycles, expected 1", tag, g);
        end
        @(negedge clk_in);
    endtask

    task automatic wait_run_en(input string tag);
        int g = 0;
        while (!run_en && g < 100) begin
            @(negedge clk_in);
            g++;
        end
        if (!run_en) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_run_en_timeout: got run_en=0 after %0d cycles, expected 1", tag, g);
        end
    endtask

    initial begin
        int e;

        // Reset dominates start and cfg_valid
        reset_in   = 1'b0;
        start      = 1'b1;
        run_cycles = 5;
        cfg_valid  = 1'b1;
        cfg_addr   = 32'hDEAD;
        cfg_data   = 32'hBEEF;
        repeat (2) begin
            @(negedge clk_in);
            check_idle("reset");
        end
        reset_in  = 1'b1;
        start     = 1'b0;
        cfg_valid = 1'b0;
        @(negedge clk_in);
        check_idle("idle");

        // Nominal: three back-to-back words, 10 run cycles
        do_start(10);
        send_word(32'h100, 32'hA1, 1'b0, e);
        send_word(32'h104, 32'hA2, 1'b0, e);
        send_word(32'h108, 32'hA3, 1'b1, e);
        expect_done(3, 10, e);
        wait_done("nominal");

        // Gap between words; last word uses the no-op address
        do_start(2);
        send_word(32'h200, 32'hB0, 1'b0, e);
        @(negedge clk_in);
        send_word(32'h0, 32'hB2, 1'b1, e);
        expect_done(2, 2, e);
        wait_done("gaps");

        // Zero run length goes straight from SETTLE to DONE
        do_start(0);
        send_word(32'h300, 32'hC0, 1'b1, e);
        expect_done(1, 0, e);
        wait_done("zero_run");

        // Abort with reset at RUN cycle 5
        do_start(20);
        send_word(32'h400, 32'hD0, 1'b1, e);
        wait_run_en("abort");
        repeat (4) @(negedge clk_in);
        reset_in = 1'b0;
        @(negedge clk_in);
        check_idle("abort");
        reset_in = 1'b1;
        @(negedge clk_in);

        // Restart; start pulses while busy must be ignored
        do_start(3);
        send_word(32'h500, 32'hE0, 1'b0, e);
        start      = 1'b1;
        run_cycles = 50;
        @(negedge clk_in);
        start = 1'b0;
        send_word(32'h504, 32'hE4, 1'b1, e);
        expect_done(2, 3, e);
        wait_run_en("restart");
        start      = 1'b1;
        run_cycles = 99;
        @(negedge clk_in);
        start = 1'b0;
        wait_done("restart");

        // Start from DONE clears status; checksum words
        do_start(1);
        check("redo_run_done", run_done, 0);
        check("redo_config_done", config_done, 0);
        check("redo_word_count", word_count, 0);
        check("redo_cycle_count", cycle_count, 0);
        check("redo_busy", busy, 1);
        check("redo_cfg_ready", cfg_ready, 1);
        send_word(32'h1, 32'h2, 1'b0, e);
        send_word(32'h4, 32'h8, 1'b1, e);
        expect_done(2, 1, e);
        wait_done("checksum");
`ifdef CFG_CHECKSUM_EN
        check("checksum_value", cfg_checksum, 32'h0000000F);
        do_start(1);
        check("checksum_cleared", cfg_checksum, 0);
        send_word(32'h10, 32'h20, 1'b1, e);
        expect_done(1, 1, e);
        wait_done("checksum2");
        check("checksum_value2", cfg_checksum, 32'h00000030);
`endif

        repeat (3) @(negedge clk_in);
        check("bus_queue_drained", bus_q.size(), 0);
        check("done_queue_drained", done_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
